// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with write-through bypass, busy scoreboard and scrub sequencer.
// Build macro R0_ZERO_EN hard-wires register 0 to zero.
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [ADDR_W-1:0] rd_a_addr,
  output logic [DATA_W-1:0] rd_a_data,
  input  logic [ADDR_W-1:0] rd_b_addr,
  output logic [DATA_W-1:0] rd_b_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_set_addr,
  output logic              busy_a,
  output logic              busy_b,
  input  logic              scrub_req,
  output logic              scrub_busy,
  output logic              scrub_done,
  output logic              wr_drop
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);

`ifdef R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [1:0]          state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                wr_drop_q, wr_drop_d;

  logic wr_in_range, sb_in_range;
  logic wr_r0, sb_r0;
  logic sweep_active;
  logic wr_ok, sb_ok;

  assign wr_in_range  = ({1'b0, wr_addr} < NUM_REGS_W);
  assign sb_in_range  = ({1'b0, sb_set_addr} < NUM_REGS_W);
  assign wr_r0        = R0_ZERO && (wr_addr == '0);
  assign sb_r0        = R0_ZERO && (sb_set_addr == '0);
  assign sweep_active = (state_q == ST_SWEEP);

  // Writes to a hard-wired zero register vanish silently; other rejected writes are reported.
  assign wr_ok     = wr_en && wr_in_range && !wr_r0 && !sweep_active;
  assign sb_ok     = sb_set && sb_in_range && !sb_r0 && !sweep_active;
  assign wr_drop_d = wr_en && !wr_r0 && (!wr_in_range || sweep_active);

  assign scrub_busy = sweep_active;
  assign scrub_done = (state_q == ST_DONE);
  assign wr_drop    = wr_drop_q;

  always_comb begin
    regs_d  = regs_q;
    busy_d  = busy_q;
    state_d = state_q;
    idx_d   = idx_q;

    // Clear-on-write is applied before set so a same-cycle set on the same register wins.
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (wr_ok && (wr_addr == i[ADDR_W-1:0])) begin
        regs_d[i] = wr_data;
        busy_d[i] = 1'b0;
      end
      if (sb_ok && (sb_set_addr == i[ADDR_W-1:0])) begin
        busy_d[i] = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (scrub_req) begin
          state_d = ST_SWEEP;
          idx_d   = '0;
        end
      end
      ST_SWEEP: begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
          if (idx_q == i[ADDR_W-1:0]) begin
            regs_d[i] = '0;
            busy_d[i] = 1'b0;
          end
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      regs_q    <= '{default: '0};
      busy_q    <= '0;
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      busy_q    <= busy_d;
      state_q   <= state_d;
      idx_q     <= idx_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Unmatched (out-of-range) addresses fall through to zero.
  always_comb begin
    rd_a_data = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rd_a_addr == i[ADDR_W-1:0]) begin
        rd_a_data = regs_q[i];
      end
    end
    if (R0_ZERO && (rd_a_addr == '0)) begin
      rd_a_data = '0;
    end
    if (BYPASS && wr_ok && (wr_addr == rd_a_addr)) begin
      rd_a_data = wr_data;
    end
  end

  always_comb begin
    rd_b_data = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rd_b_addr == i[ADDR_W-1:0]) begin
        rd_b_data = regs_q[i];
      end
    end
    if (R0_ZERO && (rd_b_addr == '0)) begin
      rd_b_data = '0;
    end
    if (BYPASS && wr_ok && (wr_addr == rd_b_addr)) begin
      rd_b_data = wr_data;
    end
  end

  always_comb begin
    busy_a = 1'b0;
    busy_b = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rd_a_addr == i[ADDR_W-1:0]) begin
        busy_a = busy_q[i];
      end
      if (rd_b_addr == i[ADDR_W-1:0]) begin
        busy_b = busy_q[i];
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: a 16-register bypassing instance and a 12-register non-bypassing instance.
module tb_reg_file_mp;

`ifdef R0_ZERO_EN
  localparam bit R0 = 1'b1;
`else
  localparam bit R0 = 1'b0;
`endif

  localparam logic [31:0] PAT_A = 32'hA5A5A5A5;
  localparam logic [31:0] PAT_B = 32'h5A5A5A5A;

  logic        clock;
  logic        clear;
  logic [3:0]  rd_a_addr, rd_b_addr, wr_addr, sb_set_addr;
  logic        wr_en, sb_set, scrub_req;
  logic [31:0] wr_data;

  logic [31:0] rd_a_data, rd_b_data;
  logic        busy_a, busy_b, scrub_busy, scrub_done, wr_drop;

  logic [31:0] c_rd_a_data, c_rd_b_data;
  logic        c_busy_a, c_busy_b, c_scrub_busy, c_scrub_done, c_wr_drop;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  reg_file_mp #(.DATA_W(32), .ADDR_W(4), .NUM_REGS(16), .BYPASS(1'b1)) dut (
    .clock(clock), .clear(clear),
    .rd_a_addr(rd_a_addr), .rd_a_data(rd_a_data),
    .rd_b_addr(rd_b_addr), .rd_b_data(rd_b_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sb_set(sb_set), .sb_set_addr(sb_set_addr),
    .busy_a(busy_a), .busy_b(busy_b),
    .scrub_req(scrub_req), .scrub_busy(scrub_busy), .scrub_done(scrub_done),
    .wr_drop(wr_drop)
  );

  reg_file_mp #(.DATA_W(32), .ADDR_W(4), .NUM_REGS(12), .BYPASS(1'b0)) dut12 (
    .clock(clock), .clear(clear),
    .rd_a_addr(rd_a_addr), .rd_a_data(c_rd_a_data),
    .rd_b_addr(rd_b_addr), .rd_b_data(c_rd_b_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sb_set(sb_set), .sb_set_addr(sb_set_addr),
    .busy_a(c_busy_a), .busy_b(c_busy_b),
    .scrub_req(scrub_req), .scrub_busy(c_scrub_busy), .scrub_done(c_scrub_done),
    .wr_drop(c_wr_drop)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_q.push_back('{tag, v});
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL no_expectation: observed=%h expected=<none>", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] preload_val(input int unsigned a, input logic [31:0] pat);
    return (R0 && a == 0) ? 32'h0 : pat;
  endfunction

  initial begin
    clear = 1'b0; wr_en = 1'b0; sb_set = 1'b0; scrub_req = 1'b0;
    rd_a_addr = '0; rd_b_addr = '0; wr_addr = '0; sb_set_addr = '0; wr_data = '0;
    step(); step();
    clear = 1'b1;

    // Reset clears a previously written register.
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEADBEEF;
    step();
    wr_en = 1'b0; rd_a_addr = 4'd5;
    expect_val("pre_reset_reg5", 32'hDEADBEEF);
    #1 check(rd_a_data);
    clear = 1'b0;
    step(); step();
    clear = 1'b1;
    expect_val("reset_reg5", 32'h0);
    expect_val("reset_busy_a", 32'h0);
    expect_val("reset_scrub_busy", 32'h0);
    expect_val("reset_scrub_done", 32'h0);
    expect_val("reset_wr_drop", 32'h0);
    #1;
    check(rd_a_data); check(32'(busy_a)); check(32'(scrub_busy));
    check(32'(scrub_done)); check(32'(wr_drop));

    // Write-through bypass (16-reg instance) versus no bypass (12-reg instance).
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h12345678; rd_a_addr = 4'd3; rd_b_addr = 4'd3;
    expect_val("bypass_rd_a", 32'h12345678);
    expect_val("bypass_rd_b", 32'h12345678);
    expect_val("nobypass_rd_a", 32'h0);
    #1;
    check(rd_a_data); check(rd_b_data); check(c_rd_a_data);
    step();
    wr_en = 1'b0;
    expect_val("after_write_rd_a", 32'h12345678);
    expect_val("nobypass_after_edge", 32'h12345678);
    #1;
    check(rd_a_data); check(c_rd_a_data);

    // Scoreboard: set, set-wins-over-write, write clears.
    sb_set = 1'b1; sb_set_addr = 4'd7; rd_a_addr = 4'd7; rd_b_addr = 4'd7;
    expect_val("busy_not_bypassed", 32'h0);
    #1 check(32'(busy_a));
    step();
    sb_set = 1'b0;
    expect_val("busy_set_a", 32'h1);
    expect_val("busy_set_b", 32'h1);
    #1;
    check(32'(busy_a)); check(32'(busy_b));
    sb_set = 1'b1; wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h00000077;
    step();
    sb_set = 1'b0; wr_en = 1'b0;
    expect_val("busy_set_wins", 32'h1);
    expect_val("reg7_written", 32'h00000077);
    #1;
    check(32'(busy_a)); check(rd_a_data);
    wr_en = 1'b1; wr_data = 32'h00000078;
    step();
    wr_en = 1'b0;
    expect_val("busy_cleared_by_write", 32'h0);
    #1 check(32'(busy_a));

    // Out-of-range write on the 12-register instance.
    wr_en = 1'b1; wr_addr = 4'd14; wr_data = 32'hCAFEF00D;
    step();
    wr_en = 1'b0; rd_a_addr = 4'd14; rd_b_addr = 4'd14;
    expect_val("oor_wr_drop", 32'h1);
    expect_val("oor_read_a", 32'h0);
    expect_val("oor_read_b", 32'h0);
    expect_val("inrange16_no_drop", 32'h0);
    expect_val("inrange16_reg14", 32'hCAFEF00D);
    #1;
    check(32'(c_wr_drop)); check(c_rd_a_data); check(c_rd_b_data);
    check(32'(wr_drop)); check(rd_a_data);
    step();
    expect_val("oor_wr_drop_one_cycle", 32'h0);
    #1 check(32'(c_wr_drop));

    // Register 0 behaviour depends on the build.
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hFFFFFFFF; rd_a_addr = 4'd0;
    expect_val("r0_same_cycle", R0 ? 32'h0 : 32'hFFFFFFFF);
    #1 check(rd_a_data);
    step();
    wr_en = 1'b0; sb_set = 1'b1; sb_set_addr = 4'd0;
    expect_val("r0_after_write", R0 ? 32'h0 : 32'hFFFFFFFF);
    expect_val("r0_no_drop", 32'h0);
    #1;
    check(rd_a_data); check(32'(wr_drop));
    step();
    sb_set = 1'b0;
    expect_val("r0_busy", R0 ? 32'h0 : 32'h1);
    #1 check(32'(busy_a));

    // Preload, then scrub; edge k is the one sampling scrub_req.
    for (int unsigned a = 0; a < 16; a++) begin
      wr_en = 1'b1; wr_addr = 4'(a); wr_data = PAT_A;
      sb_set = (a == 15); sb_set_addr = 4'd2;
      step();
    end
    wr_en = 1'b0; sb_set = 1'b0; scrub_req = 1'b1;
    step();
    scrub_req = 1'b0;
    for (int n = 1; n <= 17; n++) begin
      wr_en = (n == 4); wr_addr = 4'd12; wr_data = 32'h00001234;
      rd_a_addr = 4'((n >= 2) ? n - 2 : 0);
      rd_b_addr = 4'((n <= 16) ? n - 1 : 0);
      expect_val($sformatf("scrub_busy_c%0d", n), (n <= 16) ? 32'h1 : 32'h0);
      expect_val($sformatf("scrub_done_c%0d", n), (n == 17) ? 32'h1 : 32'h0);
      expect_val($sformatf("scrub_wr_drop_c%0d", n), (n == 5) ? 32'h1 : 32'h0);
      #1;
      check(32'(scrub_busy)); check(32'(scrub_done)); check(32'(wr_drop));
      if (n >= 2) begin
        expect_val($sformatf("swept_reg%0d", n - 2), 32'h0);
        check(rd_a_data);
      end
      if (n <= 16) begin
        expect_val($sformatf("unswept_reg%0d", n - 1), preload_val(n - 1, PAT_A));
        check(rd_b_data);
      end
      step();
    end
    wr_en = 1'b0;
    expect_val("post_scrub_done", 32'h0);
    expect_val("post_scrub_busy", 32'h0);
    #1;
    check(32'(scrub_done)); check(32'(scrub_busy));
    for (int unsigned a = 0; a < 16; a++) begin
      rd_a_addr = 4'(a);
      expect_val($sformatf("scrubbed_reg%0d", a), 32'h0);
      #1 check(rd_a_data);
    end
    rd_a_addr = 4'd2;
    expect_val("scrubbed_busy2", 32'h0);
    #1 check(32'(busy_a));

    // Reset in the middle of a sweep aborts it without a done pulse.
    for (int unsigned a = 0; a < 16; a++) begin
      wr_en = 1'b1; wr_addr = 4'(a); wr_data = PAT_B;
      step();
    end
    wr_en = 1'b0; scrub_req = 1'b1;
    step();
    scrub_req = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      expect_val($sformatf("abort_scrub_busy_c%0d", n), 32'h1);
      #1 check(32'(scrub_busy));
      if (n == 5) clear = 1'b0;
      step();
    end
    clear = 1'b1; rd_a_addr = 4'd10; rd_b_addr = 4'd15;
    expect_val("abort_reg10", 32'h0);
    expect_val("abort_reg15", 32'h0);
    expect_val("abort_busy_low", 32'h0);
    #1;
    check(rd_a_data); check(rd_b_data); check(32'(scrub_busy));
    for (int n = 0; n < 14; n++) begin
      expect_val($sformatf("abort_no_done_%0d", n), 32'h0);
      #1 check(32'(scrub_done));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port general-purpose register file for the next-generation datapath. It replaces the sixteen discrete 32-bit registers and the single-bus R-out select.
- Provides two asynchronous read ports with write-through bypass and one synchronous write port.
- Keeps a per-register busy scoreboard for the control unit.
- Includes a hardware scrub sequencer that zeroes the whole bank, one register per cycle, without a full reset.

Parameters:
- DATA_W, 32, width of each register in bits.
- ADDR_W, 4, register address width.
- NUM_REGS, 16, implemented registers; must satisfy 2 <= NUM_REGS <= 2**ADDR_W.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports.

Ports:
- clock  in  1  single system clock, rising edge.
- clear  in  1  synchronous active-low reset; the single clock and clear are fixed.
- rd_a_addr  in  ADDR_W  read port A address.
- rd_a_data  out  DATA_W  read port A data, combinational.
- rd_b_addr  in  ADDR_W  read port B address.
- rd_b_data  out  DATA_W  read port B data, combinational.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- sb_set  in  1  mark destination busy (instruction issue).
- sb_set_addr  in  ADDR_W  register to mark busy.
- busy_a  out  1  scoreboard bit of rd_a_addr.
- busy_b  out  1  scoreboard bit of rd_b_addr.
- scrub_req  in  1  request bank scrub.
- scrub_busy  out  1  high while the scrub sweep is running.
- scrub_done  out  1  one-cycle pulse when the scrub completes.
- wr_drop  out  1  one-cycle pulse when a write was discarded.

Behaviour:
- Reset: on a clock edge with clear=0, all registers and scoreboard bits go to 0, the FSM goes to IDLE, and scrub_busy, scrub_done and wr_drop go to 0. Reset mid-scrub aborts the sweep with no scrub_done.
- Write: with wr_en=1 at an edge, reg[wr_addr] <= wr_data, visible on reads in the next cycle. If wr_addr >= NUM_REGS, the write is discarded and wr_drop=1 in the next cycle.
- Read: rd_x_data = reg[rd_x_addr]. Address >= NUM_REGS reads 0.
- Bypass: when BYPASS=1, wr_en=1 and wr_addr==rd_x_addr (in range), rd_x_data = wr_data in the same cycle. When BYPASS=0, the old value is returned until the edge.
- Scoreboard:
  - sb_set sets busy[sb_set_addr] at the edge.
  - A write with wr_en clears busy[wr_addr] at the edge.
  - If both target the same address in the same cycle, the set wins (the register stays busy).
  - busy_x is the combinational view of the registered bit; out-of-range addresses read 0. Not bypassed.
- Scrub FSM, states IDLE, SWEEP, DONE:
  - IDLE: scrub_req=1 at edge k moves to SWEEP and loads the index counter with 0. scrub_req in any other state is ignored.
  - SWEEP: scrub_busy=1. Each edge zeroes reg[idx], clears busy[idx] and increments idx. The edge where idx==NUM_REGS-1 moves to DONE. The sweep occupies cycles k+1 .. k+NUM_REGS.
  - DONE: scrub_done=1 for exactly one cycle (k+NUM_REGS+1), scrub_busy=0, then IDLE.
  - wr_en while scrub_busy=1: the write is discarded and wr_drop pulses. sb_set while scrub_busy=1 is discarded as well.
  - Reads during the sweep return current contents: zeroed registers read 0, the rest hold their old values.
- All state changes happen only on the rising clock edge; there are no asynchronous paths except the combinational read and busy outputs.

Optional Feature:
- Macro R0_ZERO_EN.
- Defined:
  - Register 0 is hard-wired to zero; it reads 0 on both ports.
  - Writes to address 0 are silently ignored, with no wr_drop and no bypass.
  - sb_set to address 0 is ignored, so busy for address 0 is always 0.
- Undefined: register 0 is an ordinary register.

Test Plan:
- Reset: drive clear=0 for 2 cycles after writing reg5=32'hDEADBEEF -> rd_a_addr=5 reads 0, busy_a=0, scrub_busy=0.
- Write/read with bypass (BYPASS=1):
  - wr_en=1, wr_addr=3, wr_data=32'h12345678, rd_a_addr=3 -> rd_a_data=32'h12345678 in the same cycle.
  - In the next cycle with wr_en=0 -> still 32'h12345678.
- Scoreboard:
  - sb_set addr 7 -> busy_a=1 next cycle with rd_a_addr=7.
  - Same-cycle sb_set=7 and wr_en to 7 -> busy stays 1.
  - A later wr_en to 7 alone -> busy=0.
- Scrub (NUM_REGS=16):
  - Preload all registers with 32'hA5A5A5A5, then pulse scrub_req at cycle k.
  - Expect scrub_busy high for cycles k+1..k+16 and scrub_done high only at k+17.
  - After completion, every register reads 0.
  - A write at cycle k+4 produces a wr_drop pulse and does not land.
- Reset mid-scrub: clear=0 at cycle k+5 -> FSM returns to IDLE, all registers 0, no scrub_done pulse.
- R0_ZERO_EN defined: wr_en addr 0 with data 32'hFFFFFFFF -> rd_a_data=0 and wr_drop=0. Out-of-range write with NUM_REGS=12, addr 14 -> wr_drop pulses and reads of addr 14 return 0.
